// File: rtl/dht11_reader_pkg.sv
// Shared definitions for the DHT11 reader: FSM states, frame layout and checksum rule.
package dht11_reader_pkg;

  localparam int FRAME_BITS = 40;

  // Frame is {hum_i, hum_d, temp_i, temp_d, sum}, MSB first on the wire
  localparam int HUM_I_LSB  = 32;
  localparam int HUM_D_LSB  = 24;
  localparam int TEMP_I_LSB = 16;
  localparam int TEMP_D_LSB = 8;
  localparam int SUM_LSB    = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_LOW,
    S_WAIT_ACK,
    S_ACK_LOW,
    S_ACK_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK
  } state_t;

  function automatic logic checksum_ok(input logic [FRAME_BITS-1:0] frame);
    logic [7:0] sum;
    sum = frame[HUM_I_LSB +: 8] + frame[HUM_D_LSB +: 8]
        + frame[TEMP_I_LSB +: 8] + frame[TEMP_D_LSB +: 8];
    return sum == frame[SUM_LSB +: 8];
  endfunction

endpackage

// File: rtl/dht11_reader_us_tick_gen.sv
// One-cycle pulse every microsecond, derived from the system clock frequency.
module us_tick_gen #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);
  localparam int DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dht11_reader.sv
// DHT11 poller: drives the start pulse, decodes the 40-bit reply and holds the
// last checksum-verified integer temperature and humidity.
module dht11_reader
  import dht11_reader_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int POLL_MS       = 2000,
  parameter int START_LOW_MS  = 18,
  parameter int TIMEOUT_US    = 200,
  parameter int BIT_THRESH_US = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        dht_io,
  output logic [7:0] temperature,
  output logic [7:0] humidity,
  output logic       valid,
  output logic       err_checksum,
  output logic       err_timeout,
  output logic       busy
);
  localparam int POLL_TICKS  = POLL_MS * 1000;
  localparam int START_TICKS = START_LOW_MS * 1000;
  localparam int CNT_W       = $clog2(POLL_TICKS + START_TICKS + TIMEOUT_US + 1);
  localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_TICKS - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TICKS - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_US - 1);
  localparam logic [CNT_W-1:0] THRESH     = CNT_W'(BIT_THRESH_US);

  logic                  tick;
  logic                  sync1_q, sync2_q, prev_q;
  logic                  rise, fall;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [5:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q;
  logic                  to_hit, last_bit, bit_val, frame_ok;
  logic                  drive_low, shift_en, frame_done, timeout_evt;
  logic [7:0]            temp_q, hum_q;
  logic                  valid_q, err_cs_q, err_to_q;

  us_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk_i (clk),
    .rst_ni(rst_n),
    .tick_o(tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= dht_io;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise     = sync2_q & ~prev_q;
  assign fall     = ~sync2_q & prev_q;
  assign to_hit   = tick && (cnt_q == TO_LAST);
  assign last_bit = (bit_cnt_q == 6'(FRAME_BITS - 1));
  // cnt_q trails the true high time by one tick at the falling edge
  assign bit_val  = (cnt_q >= THRESH);
  assign frame_ok = checksum_ok(shift_q);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (tick && cnt_q == POLL_LAST)  state_d = S_START_LOW;
      S_START_LOW: if (tick && cnt_q == START_LAST) state_d = S_WAIT_ACK;
      S_WAIT_ACK:  if (fall) state_d = S_ACK_LOW;  else if (to_hit) state_d = S_IDLE;
      S_ACK_LOW:   if (rise) state_d = S_ACK_HIGH; else if (to_hit) state_d = S_IDLE;
      S_ACK_HIGH:  if (fall) state_d = S_BIT_LOW;  else if (to_hit) state_d = S_IDLE;
      S_BIT_LOW:   if (rise) state_d = S_BIT_HIGH; else if (to_hit) state_d = S_IDLE;
      S_BIT_HIGH: begin
        if (fall)        state_d = last_bit ? S_CHECK : S_BIT_LOW;
        else if (to_hit) state_d = S_IDLE;
      end
      S_CHECK:     state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    drive_low   = (state_q == S_START_LOW);
    busy        = (state_q != S_IDLE);
    frame_done  = (state_q == S_CHECK);
    shift_en    = (state_q == S_BIT_HIGH) && fall;
    // The only way out of a wait state back to IDLE is a timeout
    timeout_evt = (state_q inside {S_WAIT_ACK, S_ACK_LOW, S_ACK_HIGH, S_BIT_LOW, S_BIT_HIGH})
                  && (state_d == S_IDLE);
  end

  assign dht_io = drive_low ? 1'b0 : 1'bz;

  // One counter serves poll interval, start pulse, timeouts and bit high time
  always_comb begin
    if (state_d != state_q) cnt_d = '0;
    else if (tick)          cnt_d = cnt_q + CNT_W'(1);
    else                    cnt_d = cnt_q;
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (state_q == S_ACK_HIGH) bit_cnt_d = '0;
    else if (shift_en)         bit_cnt_d = bit_cnt_q + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) shift_q <= {shift_q[FRAME_BITS-2:0], bit_val};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      temp_q   <= '0;
      hum_q    <= '0;
      valid_q  <= 1'b0;
      err_cs_q <= 1'b0;
      err_to_q <= 1'b0;
    end else begin
      valid_q  <= frame_done && frame_ok;
      err_cs_q <= frame_done && !frame_ok;
      err_to_q <= timeout_evt;
      if (frame_done && frame_ok) begin
        hum_q  <= shift_q[HUM_I_LSB +: 8];
        temp_q <= shift_q[TEMP_I_LSB +: 8];
      end
    end
  end

  assign temperature  = temp_q;
  assign humidity     = hum_q;
  assign valid        = valid_q;
  assign err_checksum = err_cs_q;
  assign err_timeout  = err_to_q;

endmodule
